// File: rtl/mem_ctrl_4x8.sv
// mem_ctrl_4x8: sole driver of a 4-word x 8-bit level-sensitive storage array.
// It turns valid/ready requests into registered setup/strobe/hold phases on the
// array pins, captures the read data and returns it on a valid/ready response
// channel.
// Optional feature: define MEM_CTRL_WRITE_VERIFY_EN to read back every write
// and flag a mismatch on rsp_err. When the macro is undefined, rsp_err is tied to 0.
module mem_ctrl_4x8 #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The wait counter counts down to 0, so RDWAIT/VWAIT last WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, RDWAIT, VSETUP, VWAIT, RESP
    } state_e;

    state_e              state_q;
    logic                we_q;
    logic [3:0]          cnt_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    logic                rsp_err_q;
`endif

    // Sequencer: every array-side pin is a flop, so the array never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        mem_addr_q  <= req_addr;
                        mem_wdata_q <= req_wdata;
                        mem_en_q    <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (we_q) begin
                        mem_we_q <= 1'b1;
                        state_q  <= STROBE;
                    end else begin
                        cnt_q   <= WAIT_LOAD;
                        state_q <= RDWAIT;
                    end
                end
                STROBE: begin
                    mem_we_q <= 1'b0;
                    state_q  <= HOLD;
                end
                HOLD: begin
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                    // Keep mem_en high and go read the word back.
                    state_q <= VSETUP;
`else
                    mem_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    state_q     <= RESP;
`endif
                end
                RDWAIT: begin
                    if (cnt_q == 4'd0) begin
                        mem_en_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_rdata;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                VSETUP: begin
                    cnt_q   <= WAIT_LOAD;
                    state_q <= VWAIT;
                end
                VWAIT: begin
                    if (cnt_q == 4'd0) begin
                        mem_en_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_rdata;
                        rsp_err_q   <= (mem_rdata != mem_wdata_q);
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by rst_n so it drops at once while reset is asserted.
    assign req_ready = rst_n & (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl_4x8.sv
// Bench for mem_ctrl_4x8: array fixture, cycle-offset reference model,
// per-cycle compare and directed plus random stimulus.
module tb_mem_ctrl_4x8;
    localparam int W = 1;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Spec-level timing, in cycles after the accept edge.
    localparam int WR_EN_LAST  = VERIFY ? 4 + W : 3;
    localparam int WR_RSP      = VERIFY ? 5 + W : 4;
    localparam int RD_EN_LAST  = 1 + W;
    localparam int RD_RSP      = 2 + W;

    logic       clk, rst_n;
    logic       req_valid, req_ready, req_we;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       mem_en, mem_we;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    mem_ctrl_4x8 #(.ADDR_W(2), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Array fixture; optionally corrupts bit 0 of writes to address 1.
    logic       corrupt;
    logic [7:0] arr [4];
    always @(posedge clk)
        if (mem_en && mem_we)
            arr[mem_addr] <= (corrupt && mem_addr == 2'd1) ? (mem_wdata ^ 8'h01) : mem_wdata;
    assign mem_rdata = arr[mem_addr];

    // Response-ready driver: 0 = hold low, 1 = hold high, 2 = random.
    int rdy_mode;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: one outstanding transaction, tracked by accept cycle.
    bit         m_busy = 0;
    int         m_acc = 0;
    bit         m_we = 0;
    logic [1:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_exp_rd;
    bit         m_rd_known;
    bit         m_exp_err;
    logic [7:0] ref_mem [4];
    bit         known [4] = '{0, 0, 0, 0};

    initial begin
        logic [7:0] st;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                if (m_busy && m_we) known[m_addr] = 0;
                m_busy = 0; m_addr = '0; m_wdata = '0;
            end else if (m_busy) begin
                if (cyc - m_acc >= (m_we ? WR_RSP : RD_RSP) && rsp_ready) m_busy = 0;
            end else if (req_valid) begin
                m_busy = 1; m_acc = cyc; m_we = req_we;
                m_addr = req_addr; m_wdata = req_wdata;
                if (req_we) begin
                    st = (corrupt && req_addr == 2'd1) ? (req_wdata ^ 8'h01) : req_wdata;
                    ref_mem[req_addr] = st;
                    known[req_addr] = 1;
                    m_exp_rd   = VERIFY ? st : 8'h00;
                    m_rd_known = 1;
                    m_exp_err  = VERIFY && (st != req_wdata);
                end else begin
                    m_exp_rd   = ref_mem[req_addr];
                    m_rd_known = known[req_addr];
                    m_exp_err  = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    int  off;
    bit  e_en, e_we, e_vld;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
            chk("rst_rsp_err",   32'(rsp_err), 0);
            chk("rst_mem_en",    32'(mem_en), 0);
            chk("rst_mem_we",    32'(mem_we), 0);
            chk("rst_mem_addr",  32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
        end else begin
            off   = cyc - m_acc + 1;
            e_en  = m_busy && off >= 1 && off <= (m_we ? WR_EN_LAST : RD_EN_LAST);
            e_we  = m_busy && m_we && off == 2;
            e_vld = m_busy && off >= (m_we ? WR_RSP : RD_RSP);
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("mem_en",    32'(mem_en), 32'(e_en));
            chk("mem_we",    32'(mem_we), 32'(e_we));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
            chk("mem_addr",  32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            if (e_vld) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_exp_err));
                if (m_rd_known) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_exp_rd));
            end
        end
    end

    // Present one request (called at posedge+1); returns at posedge+1 after accept.
    task automatic do_req(input bit we, input logic [1:0] a, input logic [7:0] d);
        bit rdy;
        bit ok;
        ok = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL req_accept_timeout: got no accept, expected accept within 300 cycles");
        end
        #1 req_valid = 1'b0;
    endtask

    // Wait for rsp_valid after an accept; lat counts cycles from the accept edge.
    task automatic wait_rsp(output int lat, output logic [7:0] d, output logic e,
                            output int en_n, output int we_n);
        lat = -1; d = '0; e = 1'b0; en_n = 0; we_n = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = n + 1; d = rsp_rdata; e = rsp_err; break; end
            en_n += int'(mem_en);
            we_n += int'(mem_we);
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected one within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    int         lat, en_n, we_n;
    logic [7:0] d;
    logic       e;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        corrupt = 1'b0; rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready_low", 32'(req_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 1);
        chk("release_mem_en", 32'(mem_en), 0);
        @(posedge clk); #1;

        // Write 0xA5 to addr 2, read it back.
        do_req(1'b1, 2'd2, 8'hA5);
        wait_rsp(lat, d, e, en_n, we_n);
        chk("wr_latency", 32'(lat), 32'(VERIFY ? 6 : 4));
        chk("wr_we_pulse_cycles", 32'(we_n), 1);
        chk("wr_en_cycles", 32'(en_n), 32'(VERIFY ? 5 : 3));
        do_req(1'b0, 2'd2, 8'h00);
        wait_rsp(lat, d, e, en_n, we_n);
        chk("rd_latency", 32'(lat), 3);
        chk("rd_data_A5", 32'(d), 32'h0A5);
        chk("rd_en_cycles", 32'(en_n), 2);

        // All addresses, no aliasing.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 2'(i), vals[i]);
            wait_rsp(lat, d, e, en_n, we_n);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'(i), 8'h00);
            wait_rsp(lat, d, e, en_n, we_n);
            chk("all_addr_readback", 32'(d), 32'(vals[i]));
        end

        // Backpressure on a read of 0x3C, with a second request waiting.
        do_req(1'b1, 2'd0, 8'h3C);
        wait_rsp(lat, d, e, en_n, we_n);
        rdy_mode = 0;
        @(posedge clk); #1;
        do_req(1'b0, 2'd0, 8'h00);
        fork
            do_req(1'b1, 2'd3, 8'h77);
            begin
                repeat (RD_RSP + 5) @(negedge clk);
                chk("bp_rsp_valid", 32'(rsp_valid), 1);
                chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h03C);
                chk("bp_req_ready", 32'(req_ready), 0);
                chk("bp_no_access", 32'(mem_en), 0);
                @(posedge clk); #1;
                rdy_mode = 1;
            end
        join
        wait_rsp(lat, d, e, en_n, we_n);

        // Reset during STROBE of a write.
        do_req(1'b1, 2'd3, 8'h5A);
        @(posedge clk);
        #2;
        chk("strobe_we_high", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_we", 32'(mem_we), 0);
        chk("async_rst_mem_en", 32'(mem_en), 0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_idle", 32'(req_ready), 1);
        @(posedge clk); #1;

        // Write-verify: corrupted write to addr 1, then a clean one.
        corrupt = 1'b1;
        do_req(1'b1, 2'd1, 8'h0F);
        wait_rsp(lat, d, e, en_n, we_n);
        corrupt = 1'b0;
        chk("verify_latency", 32'(lat), 32'(VERIFY ? 6 : 4));
        chk("verify_err", 32'(e), 32'(VERIFY ? 1 : 0));
        chk("verify_rdata", 32'(d), 32'(VERIFY ? 8'h0E : 8'h00));
        do_req(1'b0, 2'd1, 8'h00);
        wait_rsp(lat, d, e, en_n, we_n);
        chk("corrupt_readback", 32'(d), 32'h00E);
        do_req(1'b1, 2'd1, 8'h0F);
        wait_rsp(lat, d, e, en_n, we_n);
        chk("clean_verify_err", 32'(e), 0);
        chk("clean_verify_rdata", 32'(d), 32'(VERIFY ? 8'h0F : 8'h00));

        // Random traffic with random response backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 150; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        end
        rdy_mode = 1;
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
